// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write-back port and a
// per-register busy scoreboard that exposes RAW hazards and blocks WAW issue.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              wb_en_s;
  logic              issue_fire_s;
  logic              cnt_dec_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // True when the write-back is forwarded straight to a read port this cycle.
  function automatic logic fwd_hit(input logic [ADDR_W-1:0] a, input logic en,
                                   input logic wv, input logic [ADDR_W-1:0] wa);
    return (BYPASS != 0) && en && wv && (wa == a) && !is_zero(a);
  endfunction

  // Handshake and write qualification; a same-cycle write-back frees its target for issue.
  always_comb begin
    wb_en_s      = clk_en & wb_valid & ~is_zero(wb_addr);
    issue_ready  = clk_en & ~(busy_q[issue_rd] & ~(wb_valid & (wb_addr == issue_rd)));
    issue_fire_s = issue_valid & issue_ready & ~is_zero(issue_rd);
    cnt_dec_s    = wb_en_s & busy_q[wb_addr];
  end

  // Next busy vector: issue sets after write-back clears, so a new producer wins.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = (issue_fire_s & (issue_rd == ADDR_W'(i)))
                | (busy_q[i] & ~(wb_en_s & (wb_addr == ADDR_W'(i))));
    end
    cnt_d = cnt_q + (ADDR_W + 1)'(issue_fire_s) - (ADDR_W + 1)'(cnt_dec_s);
  end

  // Register, busy and count state; everything holds while clk_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (clk_en) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wb_en_s) begin
        regs_q[wb_addr] <= wb_data;
      end
    end
  end

  // Read ports, with optional same-cycle forwarding of the write-back.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs1_busy = busy_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    rs2_busy = busy_q[rs2_addr];
    if (is_zero(rs1_addr)) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end else if (fwd_hit(rs1_addr, clk_en, wb_valid, wb_addr)) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
    if (is_zero(rs2_addr)) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end else if (fwd_hit(rs2_addr, clk_en, wb_valid, wb_addr)) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding and a non-forwarding instance
// share stimulus; expectations are hand-computed constants.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [3:0] rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic       issue_valid, wb_valid;
  logic [7:0] wb_data;

  logic [7:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic       a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic       a_issue_ready, b_issue_ready;
  logic [4:0] a_busy_cnt, b_busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(a_issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_cnt(a_busy_cnt)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(b_issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_cnt(b_busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    clk_en      = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; issue_valid = 1'b0; wb_valid = 1'b0;
    issue_rd = 4'd0; wb_addr = 4'd0; wb_data = 8'h00;
    rs1_addr = 4'd5; rs2_addr = 4'd5;
    tick();
    check("reset_cnt", a_busy_cnt, 5'd0);
    check("reset_data", a_rs1_data, 8'h00);
    rst = 1'b0;
    tick();

    // issue rd=5, then a second issue to 5 must stall
    issue_valid = 1'b1; issue_rd = 4'd5; #1;
    check("issue5_ready", a_issue_ready, 1'b1);
    tick();
    check("issue5_busy", a_rs1_busy, 1'b1);
    check("issue5_cnt", a_busy_cnt, 5'd1);
    check("issue5_again_ready", a_issue_ready, 1'b0);
    issue_valid = 1'b0;

    // write-back 5 = 0xA7
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 8'hA7; #1;
    check("wb5_fwd_data", a_rs1_data, 8'hA7);
    check("wb5_fwd_busy", a_rs1_busy, 1'b0);
    check("wb5_nb_data", b_rs1_data, 8'h00);
    check("wb5_nb_busy", b_rs1_busy, 1'b1);
    tick();
    wb_valid = 1'b0; #1;
    check("wb5_data", a_rs1_data, 8'hA7);
    check("wb5_nb_data_next", b_rs1_data, 8'hA7);
    check("wb5_cnt", a_busy_cnt, 5'd0);

    // bypass to both ports on addr 3
    rs1_addr = 4'd3; rs2_addr = 4'd3;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 8'h5C; #1;
    check("byp_rs1", a_rs1_data, 8'h5C);
    check("byp_rs2", a_rs2_data, 8'h5C);
    check("byp_busy2", a_rs2_busy, 1'b0);
    check("nb_old_rs1", b_rs1_data, 8'h00);
    tick();
    wb_valid = 1'b0; #1;
    check("nb_new_rs1", b_rs1_data, 8'h5C);
    check("nb_new_rs2", b_rs2_data, 8'h5C);

    // same-cycle issue + write-back on busy reg 7
    rs1_addr = 4'd7;
    issue_valid = 1'b1; issue_rd = 4'd7;
    tick();
    check("iss7_cnt", a_busy_cnt, 5'd1);
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 8'h11; #1;
    check("iss7wb_ready", a_issue_ready, 1'b1);
    tick();
    idle(); #1;
    check("iss7wb_data", a_rs1_data, 8'h11);
    check("iss7wb_busy", a_rs1_busy, 1'b1);
    check("iss7wb_cnt", a_busy_cnt, 5'd1);
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 8'h22;
    tick();
    idle(); #1;
    check("wb7_cnt", a_busy_cnt, 5'd0);
    check("wb7_data", a_rs1_data, 8'h22);

    // zero register: write and issue are ignored
    rs1_addr = 4'd0;
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 8'hFF;
    issue_valid = 1'b1; issue_rd = 4'd0; #1;
    check("zero_ready", a_issue_ready, 1'b1);
    check("zero_fwd", a_rs1_data, 8'h00);
    tick();
    idle(); #1;
    check("zero_data", a_rs1_data, 8'h00);
    check("zero_busy", a_rs1_busy, 1'b0);
    check("zero_cnt", a_busy_cnt, 5'd0);

    // clk_en low freezes state and disables forwarding
    rs1_addr = 4'd3; rs2_addr = 4'd9; clk_en = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 8'h99;
    issue_valid = 1'b1; issue_rd = 4'd9; #1;
    check("gate_ready", a_issue_ready, 1'b0);
    check("gate_nofwd", a_rs1_data, 8'h5C);
    tick();
    idle(); #1;
    check("gate_data", a_rs1_data, 8'h5C);
    check("gate_busy9", a_rs2_busy, 1'b0);
    check("gate_cnt", a_busy_cnt, 5'd0);

    // fill every non-zero register busy
    for (int r = 1; r < 16; r++) begin
      issue_valid = 1'b1; issue_rd = 4'(r); #1;
      check($sformatf("fill_ready_%0d", r), a_issue_ready, 1'b1);
      tick();
    end
    idle(); rs2_addr = 4'd15; #1;
    check("fill_cnt", a_busy_cnt, 5'd15);
    check("fill_cnt_nb", b_busy_cnt, 5'd15);
    check("fill_busy15", a_rs2_busy, 1'b1);
    issue_rd = 4'd4; #1;
    check("fill_stall4", a_issue_ready, 1'b0);

    // asynchronous reset between edges
    #2 rst = 1'b1; #1;
    check("arst_data", a_rs1_data, 8'h00);
    check("arst_busy", a_rs2_busy, 1'b0);
    check("arst_cnt", a_busy_cnt, 5'd0);
    tick();
    rst = 1'b0;
    tick();
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 8'h3C; rs1_addr = 4'd2;
    tick();
    idle(); #1;
    check("post_rst_wb", b_rs1_data, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
